// File: rtl/clint_vec_pkg.sv
// Shared constants for the vectored core-local interrupt arbiter: cause codes,
// mie/mstatus bit positions, CSR addresses, opcodes and state encodings.
package clint_vec_pkg;

    localparam logic [31:0] CAUSE_ECALL    = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
    localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_BASE = 32'h8000_0010;

    localparam int MIE_MTIE     = 7;
    localparam int MIE_IRQ_BASE = 16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    localparam logic [31:0] CSR_MSTATUS = 32'h300;
    localparam logic [31:0] CSR_MEPC    = 32'h341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h342;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;
    localparam logic [1:0] PRIV_MACHINE   = 2'b11;

    localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INS_MRET   = 32'h3020_0073;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEPC,
        ST_MSTATUS,
        ST_MCAUSE,
        ST_MRET
    } state_t;

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_SYNC,
        ARB_ASYNC,
        ARB_MRET
    } arb_t;

    // div, divu, rem and remu all share funct3[2] = 1 within the M extension
    function automatic logic is_div(input logic [31:0] ins);
        return (ins[6:0] == OPC_OP) && (ins[31:25] == FUNCT7_MULDIV) && ins[14];
    endfunction

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms, input logic [1:0] priv);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP +: 2] = priv;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP +: 2] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/clint_vec_irq_pending.sv
// Per-line pending capture for the platform interrupt lines: rising-edge latch
// with ack clear (new edge wins), or straight level pass-through.
module clint_vec_irq_pending #(
    parameter int NUM_IRQ  = 8,
    parameter int IRQ_EDGE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] ack,
    output logic [NUM_IRQ-1:0] pending
);

    generate
        if (IRQ_EDGE != 0) begin : g_edge
            for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
                logic prev_reg;
                logic pend_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        prev_reg <= 1'b0;
                        pend_reg <= 1'b0;
                    end else begin
                        prev_reg <= irq[gi];
                        if (irq[gi] && !prev_reg) begin
                            pend_reg <= 1'b1;
                        end else if (ack[gi]) begin
                            pend_reg <= 1'b0;
                        end
                    end
                end

                assign pending[gi] = pend_reg;
            end
        end else begin : g_level
            logic unused_level;
            assign unused_level = ^{ack, clk, rst_n};
            assign pending      = irq;
        end
    endgenerate

endmodule

// File: rtl/clint_vec.sv
// Vectored core-local interrupt arbiter: fixed-priority trap selection, CSR
// write sequencing (mepc, mstatus, mcause) and trap/mret redirect to CU.
module clint_vec #(
    parameter int NUM_IRQ   = 8,
    parameter int IRQ_EDGE  = 1,
    parameter int VECTOR_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        ins_i,
    input  logic [31:0]        ins_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               div_req_i,
    input  logic               div_busy_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    input  logic [31:0]        csr_mie,
    input  logic [1:0]         privileg_i,
    input  logic               timer_irq_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               wr_en_o,
    output logic [31:0]        wr_addr_o,
    output logic [31:0]        wr_data_o,
    output logic               wr_privilege_en_o,
    output logic [1:0]         wr_privilege_o,
    output logic [NUM_IRQ-1:0] irq_pending_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic               clint_busy_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o
);

    import clint_vec_pkg::*;

    state_t             state_reg;
    arb_t               arb;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_masked;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [NUM_IRQ-1:0] ack_mask_reg;
    logic [3:0]         irq_idx;
    logic               irq_hit;
    logic               plat_next;
    logic               sys_ins;
    logic               async_reg;
    logic [31:0]        cause_next;
    logic [31:0]        epc_next;
    logic [31:0]        async_epc;
    logic [31:0]        cause_reg;
    logic [31:0]        div_addr_reg;
    logic [31:0]        trap_base;
    logic [31:0]        trap_target;
    logic               unused_mie;

    clint_vec_irq_pending #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq     (irq_i),
        .ack     (irq_ack_o),
        .pending (pending)
    );

    assign irq_pending_o = pending;
    assign irq_masked    = pending & csr_mie[MIE_IRQ_BASE +: NUM_IRQ];
    assign unused_mie    = ^csr_mie;

    // Lowest enabled line wins: scanning downwards lets the last hit stick
    always_comb begin
        irq_hit    = 1'b0;
        irq_idx    = '0;
        irq_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_masked[i]) begin
                irq_hit       = 1'b1;
                irq_idx       = i[3:0];
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
    end

    assign sys_ins   = (ins_i == INS_ECALL) || (ins_i == INS_EBREAK);
    assign async_epc = (div_req_i || div_busy_i) ? div_addr_reg :
                       jump_flag_i               ? jump_addr_i  : ins_addr_i;

    always_comb begin
        arb        = ARB_NONE;
        cause_next = '0;
        epc_next   = ins_addr_i;
        plat_next  = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (sys_ins) begin
                // An ecall/ebreak shadowed by a divide or redirect blocks everything
                if (!div_req_i && !jump_flag_i) begin
                    arb        = ARB_SYNC;
                    cause_next = (ins_i == INS_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
                end
            end else if (csr_mstatus[MSTATUS_MIE] && timer_irq_i && csr_mie[MIE_MTIE]) begin
                arb        = ARB_ASYNC;
                cause_next = CAUSE_TIMER;
                epc_next   = async_epc;
            end else if (csr_mstatus[MSTATUS_MIE] && irq_hit) begin
                arb        = ARB_ASYNC;
                cause_next = CAUSE_IRQ_BASE | {28'b0, irq_idx};
                epc_next   = async_epc;
                plat_next  = 1'b1;
            end else if (ins_i == INS_MRET) begin
                arb = ARB_MRET;
            end
        end
    end

    assign clint_busy_o = (arb != ARB_NONE) || (state_reg != ST_IDLE);

    assign trap_base   = {csr_mtvec[31:2], 2'b00};
    assign trap_target = ((VECTOR_EN != 0) && async_reg && (csr_mtvec[1:0] == MTVEC_VECTORED)) ?
                         trap_base + {25'b0, cause_reg[4:0], 2'b00} : trap_base;

    // Each state register value names the CSR write currently on the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            cause_reg         <= '0;
            async_reg         <= 1'b0;
            ack_mask_reg      <= '0;
            div_addr_reg      <= '0;
            wr_en_o           <= 1'b0;
            wr_addr_o         <= '0;
            wr_data_o         <= '0;
            wr_privilege_en_o <= 1'b0;
            wr_privilege_o    <= PRIV_MACHINE;
            irq_ack_o         <= '0;
            int_assert_o      <= 1'b0;
            int_addr_o        <= '0;
        end else begin
            wr_en_o           <= 1'b0;
            wr_addr_o         <= '0;
            wr_data_o         <= '0;
            wr_privilege_en_o <= 1'b0;
            irq_ack_o         <= '0;
            int_assert_o      <= 1'b0;
            int_addr_o        <= '0;

            if (is_div(ins_i)) begin
                div_addr_reg <= ins_addr_i;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (arb == ARB_SYNC || arb == ARB_ASYNC) begin
                        state_reg    <= ST_MEPC;
                        cause_reg    <= cause_next;
                        async_reg    <= (arb == ARB_ASYNC);
                        ack_mask_reg <= plat_next ? irq_onehot : '0;
                        wr_en_o      <= 1'b1;
                        wr_addr_o    <= CSR_MEPC;
                        wr_data_o    <= epc_next;
                    end else if (arb == ARB_MRET) begin
                        state_reg         <= ST_MRET;
                        wr_en_o           <= 1'b1;
                        wr_addr_o         <= CSR_MSTATUS;
                        wr_data_o         <= mret_mstatus(csr_mstatus);
                        wr_privilege_en_o <= 1'b1;
                        wr_privilege_o    <= csr_mstatus[MSTATUS_MPP +: 2];
                        int_assert_o      <= 1'b1;
                        int_addr_o        <= csr_mepc;
                    end
                end
                ST_MEPC: begin
                    state_reg         <= ST_MSTATUS;
                    wr_en_o           <= 1'b1;
                    wr_addr_o         <= CSR_MSTATUS;
                    wr_data_o         <= trap_mstatus(csr_mstatus, privileg_i);
                    wr_privilege_en_o <= 1'b1;
                    wr_privilege_o    <= PRIV_MACHINE;
                end
                ST_MSTATUS: begin
                    state_reg    <= ST_MCAUSE;
                    wr_en_o      <= 1'b1;
                    wr_addr_o    <= CSR_MCAUSE;
                    wr_data_o    <= cause_reg;
                    int_assert_o <= 1'b1;
                    int_addr_o   <= trap_target;
                    irq_ack_o    <= ack_mask_reg;
                end
                ST_MCAUSE: begin
                    state_reg <= ST_IDLE;
                end
                ST_MRET: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_vec.sv
// Scoreboard bench for clint_vec: a cycle-level reference model predicts each
// redirect, a separate monitor checks the CSR writes and redirect against it.
`timescale 1ns/1ps
module tb_clint_vec;

    localparam int NUM_IRQ = 8;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] DIV    = 32'h02C5_C533;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [31:0]        ins, ins_addr, jump_addr, mtvec, mepc_in, mstatus_in, mie;
    logic               jump_flag, div_req, div_busy, timer;
    logic [1:0]         priv;
    logic [NUM_IRQ-1:0] irq;

    logic               wr_en_o, wr_privilege_en_o, clint_busy_o, int_assert_o;
    logic [31:0]        wr_addr_o, wr_data_o, int_addr_o;
    logic [1:0]         wr_privilege_o;
    logic [NUM_IRQ-1:0] irq_pending_o, irq_ack_o;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    clint_vec #(.NUM_IRQ(NUM_IRQ), .IRQ_EDGE(1), .VECTOR_EN(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ins_i             (ins),
        .ins_addr_i        (ins_addr),
        .jump_flag_i       (jump_flag),
        .jump_addr_i       (jump_addr),
        .div_req_i         (div_req),
        .div_busy_i        (div_busy),
        .csr_mtvec         (mtvec),
        .csr_mepc          (mepc_in),
        .csr_mstatus       (mstatus_in),
        .csr_mie           (mie),
        .privileg_i        (priv),
        .timer_irq_i       (timer),
        .irq_i             (irq),
        .wr_en_o           (wr_en_o),
        .wr_addr_o         (wr_addr_o),
        .wr_data_o         (wr_data_o),
        .wr_privilege_en_o (wr_privilege_en_o),
        .wr_privilege_o    (wr_privilege_o),
        .irq_pending_o     (irq_pending_o),
        .irq_ack_o         (irq_ack_o),
        .clint_busy_o      (clint_busy_o),
        .int_assert_o      (int_assert_o),
        .int_addr_o        (int_addr_o)
    );

    typedef struct {
        int                 due;
        logic               is_mret;
        logic [31:0]        mepc;
        logic [31:0]        mstatus;
        logic [31:0]        mcause;
        logic [31:0]        target;
        logic [1:0]         priv;
        logic [NUM_IRQ-1:0] ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    logic [NUM_IRQ-1:0] m_pend, m_prev, m_ack_mask;
    logic [31:0]        m_div_addr;
    int                 m_busy, m_ack_cycle;

    logic [31:0] seen_mepc, seen_ms;
    logic [1:0]  seen_priv;
    logic [2:0]  got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock of stimulus: inputs are already driven at the falling edge.
    task automatic step();
        int                 kind;
        exp_t               e;
        logic [31:0]        cause, epc, base;
        logic [NUM_IRQ-1:0] en_pend, ack_now;
        #1;
        kind    = 0;
        cause   = '0;
        epc     = ins_addr;
        e.ack   = '0;
        en_pend = m_pend & mie[16 +: NUM_IRQ];
        if (m_busy == 0) begin
            if (ins == ECALL || ins == EBREAK) begin
                if (!div_req && !jump_flag) begin
                    kind  = 1;
                    cause = (ins == ECALL) ? 32'd11 : 32'd3;
                end
            end else if (mstatus_in[3] && timer && mie[7]) begin
                kind  = 2;
                cause = 32'h8000_0007;
            end else if (mstatus_in[3] && en_pend != 0) begin
                kind = 2;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (en_pend[i]) begin
                        cause    = 32'h8000_0010 + 32'(i);
                        e.ack[i] = 1'b1;
                        break;
                    end
                end
            end else if (ins == MRET) begin
                kind = 3;
            end
        end
        if (kind == 2) epc = (div_req || div_busy) ? m_div_addr : (jump_flag ? jump_addr : ins_addr);
        chk("clint_busy", 32'(clint_busy_o), 32'((m_busy != 0) || (kind != 0)));

        if (kind == 1 || kind == 2) begin
            e.due     = cyc + 3;
            e.is_mret = 1'b0;
            e.mepc    = epc;
            e.mcause  = cause;
            e.priv    = 2'b11;
            e.mstatus = mstatus_in;
            e.mstatus[7]     = mstatus_in[3];
            e.mstatus[3]     = 1'b0;
            e.mstatus[12:11] = priv;
            base      = mtvec & 32'hFFFF_FFFC;
            e.target  = (kind == 2 && mtvec[1:0] == 2'b01) ? base + (cause & 32'h1F) * 4 : base;
            exp_q.push_back(e);
            m_busy = 3;
            if (e.ack != 0) begin
                m_ack_cycle = cyc + 3;
                m_ack_mask  = e.ack;
            end
        end else if (kind == 3) begin
            e.due     = cyc + 1;
            e.is_mret = 1'b1;
            e.mepc    = '0;
            e.mcause  = '0;
            e.priv    = mstatus_in[12:11];
            e.mstatus = mstatus_in;
            e.mstatus[3]     = mstatus_in[7];
            e.mstatus[7]     = 1'b1;
            e.mstatus[12:11] = 2'b00;
            e.target  = mepc_in;
            exp_q.push_back(e);
            m_busy = 1;
        end else if (m_busy > 0) begin
            m_busy--;
        end

        ack_now = (cyc == m_ack_cycle) ? m_ack_mask : '0;
        m_pend  = (m_pend & ~ack_now) | (irq & ~m_prev);
        m_prev  = irq;
        if (ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001 && ins[14]) m_div_addr = ins_addr;

        @(negedge clk);
        chk("irq_pending", 32'(irq_pending_o), 32'(m_pend));
    endtask

    task automatic idle(input int n);
        ins       = NOP;
        timer     = 1'b0;
        div_req   = 1'b0;
        div_busy  = 1'b0;
        jump_flag = 1'b0;
        repeat (n) step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wr_en_o && wr_addr_o == 32'h341) begin seen_mepc = wr_data_o; got[2] = 1'b1; end
                if (wr_en_o && wr_addr_o == 32'h300) begin seen_ms = wr_data_o; got[1] = 1'b1; end
                if (wr_privilege_en_o) begin seen_priv = wr_privilege_o; got[0] = 1'b1; end
                if (int_assert_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_redirect: got int_addr %h expected no redirect (cycle %0d)", int_addr_o, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", 32'(cyc), 32'(e.due));
                        chk("int_addr", int_addr_o, e.target);
                        chk("mstatus", seen_ms, e.mstatus);
                        chk("privilege", 32'(seen_priv), 32'(e.priv));
                        chk("writes_seen", 32'(got), e.is_mret ? 32'd3 : 32'd7);
                        chk("irq_ack", 32'(irq_ack_o), 32'(e.ack));
                        if (!e.is_mret) begin
                            chk("mepc", seen_mepc, e.mepc);
                            chk("mcause_addr", wr_addr_o, 32'h342);
                            chk("mcause", wr_data_o, e.mcause);
                        end
                    end
                    got = '0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        ins = NOP; ins_addr = '0; jump_addr = '0; jump_flag = 1'b0;
        div_req = 1'b0; div_busy = 1'b0; timer = 1'b0; irq = '0;
        mtvec = '0; mepc_in = '0; mstatus_in = '0; mie = '0; priv = 2'b00;
        m_pend = '0; m_prev = '0; m_ack_mask = '0; m_div_addr = '0;
        m_busy = 0; m_ack_cycle = -1; got = '0;
        seen_mepc = '0; seen_ms = '0; seen_priv = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_wr_en", 32'(wr_en_o), 32'd0);
        chk("reset_wr_data", wr_data_o, 32'd0);
        chk("reset_priv", 32'(wr_privilege_o), 32'd3);
        chk("reset_int_assert", 32'(int_assert_o), 32'd0);
        chk("reset_pending", 32'(irq_pending_o), 32'd0);
        chk("reset_busy", 32'(clint_busy_o), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ecall, direct mtvec
        mtvec = 32'h200; mstatus_in = 32'h8; mie = '0; priv = 2'b00;
        ins = ECALL; ins_addr = 32'h100;
        step();
        idle(5);

        // ebreak shadowed by a redirect, then taken
        ins = EBREAK; ins_addr = 32'h300; jump_flag = 1'b1; jump_addr = 32'h380;
        step();
        jump_flag = 1'b0;
        step();
        idle(5);

        // platform line 2, vectored
        mtvec = 32'h201; mie = 32'h1 << 18;
        irq = 8'h04;
        idle(8);
        irq = '0;
        idle(1);

        // timer and line 0 together
        mtvec = 32'h200; mie = (32'h1 << 7) | (32'h1 << 16);
        timer = 1'b1; irq = 8'h01;
        step();
        idle(10);
        irq = '0;
        idle(1);

        // masked line 1 stays pending, then unmasked
        mie = '0; irq = 8'h02;
        idle(4);
        mie = 32'h1 << 17;
        idle(6);
        irq = '0;
        idle(1);

        // return address from divider, then from redirect
        mie = 32'h1 << 7;
        ins = DIV; ins_addr = 32'h40;
        step();
        ins = NOP; ins_addr = 32'h44; div_busy = 1'b1; timer = 1'b1;
        step();
        idle(5);
        ins_addr = 32'h48; jump_flag = 1'b1; jump_addr = 32'h80; timer = 1'b1;
        step();
        idle(5);

        // mret
        mstatus_in = 32'h80; priv = 2'b11; mepc_in = 32'h1234;
        ins = MRET;
        step();
        idle(3);

        // randomized traffic
        for (int k = 0; k < 700; k++) begin
            int r;
            if (m_busy == 0) begin
                mtvec      = $urandom;
                mstatus_in = $urandom;
                if ($urandom_range(0, 3) != 0) mstatus_in[3] = 1'b1;
                mie        = $urandom;
                priv       = 2'($urandom_range(0, 3));
                mepc_in    = $urandom;
            end
            r = $urandom_range(0, 31);
            if (r < 2)       ins = ECALL;
            else if (r < 4)  ins = EBREAK;
            else if (r < 6)  ins = MRET;
            else if (r < 10) ins = 32'h02C5_8533 | (32'($urandom_range(4, 7)) << 12);
            else if (r < 11) ins = 32'h02C5_8533;
            else             ins = NOP;
            ins_addr  = $urandom & 32'hFFFF_FFFC;
            jump_addr = $urandom & 32'hFFFF_FFFC;
            jump_flag = ($urandom_range(0, 7) == 0);
            div_req   = ($urandom_range(0, 7) == 0);
            div_busy  = ($urandom_range(0, 7) == 0);
            timer     = ($urandom_range(0, 7) == 0);
            irq       = irq ^ NUM_IRQ'($urandom & $urandom & $urandom);
            step();
        end

        irq = '0;
        ins = NOP; timer = 1'b0; div_req = 1'b0; div_busy = 1'b0; jump_flag = 1'b0;
        for (int k = 0; k < 12 && m_busy != 0; k++) step();
        mie = '0; mstatus_in = '0;
        idle(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a trap sequence, with a line pending
        mstatus_in = 32'h8; mtvec = 32'h200;
        ins = ECALL; ins_addr = 32'h500; irq = 8'h08;
        step();
        mon_en = 1'b0;
        exp_q.delete();
        ins = NOP;
        step();
        chk("mid_in_mstatus", wr_addr_o, 32'h300);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en_o), 32'd0);
        chk("midrst_wr_addr", wr_addr_o, 32'd0);
        chk("midrst_wr_data", wr_data_o, 32'd0);
        chk("midrst_priv_en", 32'(wr_privilege_en_o), 32'd0);
        chk("midrst_priv", 32'(wr_privilege_o), 32'd3);
        chk("midrst_pending", 32'(irq_pending_o), 32'd0);
        chk("midrst_busy", 32'(clint_busy_o), 32'd0);
        @(negedge clk);
        chk("midrst_no_pulse", 32'(int_assert_o), 32'd0);
        chk("midrst_no_ack", 32'(irq_ack_o), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clint_vec.md
Name: clint_vec

Overview:
- Parametrised, vectored successor to the core-local interrupt arbiter.
- Sits between EX/CU and the CSR file. Arbitrates synchronous exceptions (ecall, ebreak), a timer interrupt and NUM_IRQ platform interrupt lines with fixed priority, per-source mie masking and edge/level pending capture.
- Sequences the mepc/mstatus/mcause CSR writes, then issues a trap or mret redirect to CU.
- Supports direct and vectored mtvec modes.

Parameters:
- NUM_IRQ, 8: number of platform interrupt lines; legal range 1..16. Line i maps to cause 16+i and mie/mip bit 16+i.
- IRQ_EDGE, 1: 1 = platform lines are rising-edge latched into pending; 0 = level (pending = irq_i).
- VECTOR_EN, 1: 1 = honour mtvec MODE = 01 (vectored) for async traps; 0 = always direct.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- ins_i  in  32  instruction in EX
- ins_addr_i  in  32  address of ins_i
- jump_flag_i  in  1  EX redirect this cycle
- jump_addr_i  in  32  EX redirect target
- div_req_i  in  1  divide start request
- div_busy_i  in  1  divider busy
- csr_mtvec  in  32  mtvec
- csr_mepc  in  32  mepc
- csr_mstatus  in  32  mstatus
- csr_mie  in  32  mie
- privileg_i  in  2  current privilege
- timer_irq_i  in  1  timer interrupt, level
- irq_i  in  NUM_IRQ  platform interrupt lines
- wr_en_o  out  1  CSR write enable
- wr_addr_o  out  32  CSR write address
- wr_data_o  out  32  CSR write data
- wr_privilege_en_o  out  1  privilege write enable
- wr_privilege_o  out  2  new privilege
- irq_pending_o  out  NUM_IRQ  pending vector, fed to mip[16+:NUM_IRQ]
- irq_ack_o  out  NUM_IRQ  one-hot pulse when a line's trap is taken
- clint_busy_o  out  1  stall request to CU
- int_assert_o  out  1  redirect pulse
- int_addr_o  out  32  redirect target

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs reset to 0, except wr_privilege_o, which resets to machine (2'b11). State resets to IDLE; the pending vector and edge-history registers reset to 0.
- Pending capture: with IRQ_EDGE=1, pending[i] is set when irq_i[i] is 1 and was 0 in the previous cycle. It is cleared in the cycle irq_ack_o[i] pulses; if a new edge arrives in that same cycle, set wins. With IRQ_EDGE=0, pending = irq_i and no clearing applies.
- Combinational arbitration, in priority order, evaluated only in IDLE:
  - (1) ins_i is ecall or ebreak, and div_req_i=0 and jump_flag_i=0 -> SYNC. If either div_req_i or jump_flag_i is 1, nothing is taken this cycle.
  - (2) mstatus[3]=1 and (timer_irq_i & csr_mie[7]) -> ASYNC, cause 0x80000007.
  - (3) mstatus[3]=1 and the lowest index i with pending[i] & csr_mie[16+i] -> ASYNC, cause 0x80000000|(16+i).
  - (4) ins_i is mret -> MRET.
- Captured return address (ASYNC): div_ins_addr if div_req_i or div_busy_i; else jump_addr_i if jump_flag_i; else ins_addr_i. div_ins_addr is registered whenever ins_i is div/divu/rem/remu.
- Captured return address (SYNC): ins_addr_i. Sync cause is 11 for ecall, 3 for ebreak.
- State machine: IDLE -> MEPC -> MSTATUS -> MCAUSE -> IDLE for traps; IDLE -> MRET -> IDLE for mret. One state per cycle, no stalls.
- Outputs are registered from the current state; wr_en_o is 0 in IDLE.
  - MEPC: write mepc with the captured address.
  - MSTATUS: write mstatus with MPIE := old MIE, MIE := 0, MPP := privileg_i, all other bits unchanged. Also privilege := machine.
  - MCAUSE: write mcause with cause. Also int_assert_o=1 and irq_ack_o one-hot if the source was a platform line.
  - MRET: write mstatus with MIE := MPIE, MPIE := 1, MPP := 00. Also privilege := old MPP, int_assert_o=1, int_addr_o=csr_mepc.
- Trap latency: arbitration in cycle N; int_assert_o is high in cycle N+3 for exactly one cycle. MRET: int_assert_o is high in cycle N+1.
- Trap target address:
  - Direct: {mtvec[31:2], 2'b00}.
  - Vectored: when VECTOR_EN=1, mtvec[1:0]=01 and the trap is ASYNC, target = base + 4*(cause[4:0]).
  - Sync traps always use base.
- clint_busy_o = (arbitration result is not none) | (state != IDLE). It is combinational so CU freezes in cycle N.
- Simultaneous events: sync beats async; timer beats platform lines; async beats mret. A pending source masked by mie stays pending. Sources arriving while not IDLE are held (edge mode) and arbitrated on return to IDLE.
- Reset mid-sequence: abort, no partial pulse; pending is cleared.

Decomposition:
- Shared defines: cause codes, mie bit indices, CSR addresses, state encodings, the MTVEC_VECTORED constant, and the ecall/ebreak/mret/div opcodes.
- Sub-module irq_pending (edge detect, pending register and ack clear, NUM_IRQ wide) feeding a lowest-index priority encoder in clint_vec.

Test Plan:
- ecall at 0x100, mtvec=0x200, MIE=1 -> mepc=0x100, mcause=11, mstatus MIE=0/MPIE=1, int_addr_o=0x200 at N+3.
- irq_i[2] rising edge, mie[18]=1, mtvec=0x201, vectored -> mcause=0x80000012, int_addr_o=0x248, irq_ack_o=0x04, pending[2] cleared.
- timer and irq_i[0] together -> timer taken (0x80000007); irq0 taken after the sequence completes, with mcause 0x80000010.
- irq_i[1] with mie[17]=0 -> no trap, irq_pending_o[1]=1. Set mie[17] -> trap taken.
- Async during div_busy_i with div at 0x40 -> mepc=0x40. With jump_flag_i and jump_addr_i=0x80 -> mepc=0x80.
- mret with mstatus MPIE=1 and MPP=00 -> MIE=1, privilege=00, int_addr_o=csr_mepc at N+1. Reset asserted in MSTATUS -> all outputs 0 next cycle.
